dma_wr_streamer: RTL and testbench
==================================

Name: dma_wr_streamer

Overview:
Consumer end of the DMA data FIFO. It pops beats from the FIFO's first-word-fall-through head and drives them onto the AXI4 write-data (W) channel as one burst per accepted command. It generates WSTRB, WLAST and the FIFO pop, and signals burst completion to the DMA channel controller. It sits between dma_fifo (read side) and the AXI master W port.

Parameters:
DATA_WIDTH, 32, W/FIFO data width in bits; must be a multiple of 8.
FIFO_DEPTH, 16, slot count of the attached FIFO; sizes fifo_ocup_i.
STRB_WIDTH, DATA_WIDTH/8, derived byte-lane count; do not override.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_valid_i  in  1  burst command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_len_i  in  8  beats-1 (AXI AxLEN encoding)
cmd_first_strb_i  in  STRB_WIDTH  byte strobe for the first beat
cmd_last_strb_i  in  STRB_WIDTH  byte strobe for the last beat
fifo_data_i  in  DATA_WIDTH  FIFO head data (combinational)
fifo_empty_i  in  1  FIFO empty
fifo_ocup_i  in  $clog2(FIFO_DEPTH)+1  FIFO occupancy
fifo_read_o  out  1  pop FIFO head this cycle
wdata_o  out  DATA_WIDTH  AXI WDATA
wstrb_o  out  STRB_WIDTH  AXI WSTRB
wlast_o  out  1  AXI WLAST
wvalid_o  out  1  AXI WVALID
wready_i  in  1  AXI WREADY
busy_o  out  1  burst in progress
done_o  out  1  one-cycle pulse after the last beat handshake
err_o  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset: state IDLE, beat counter 0, first-beat flag 0, latched strobes 0. Outputs after reset: cmd_ready_o=1, wvalid_o=0, wlast_o=0, fifo_read_o=0, busy_o=0, done_o=0, err_o=0.
- FSM states:
  - IDLE: cmd_ready_o=1. On accept, latch len, first_strb and last_strb, set beat_cnt=len and first=1, then go to STREAM, or to WAIT_DATA when the macro is enabled.
  - WAIT_DATA (macro only): see Optional Feature.
  - STREAM: cmd_ready_o=0, busy_o=1.
- STREAM signalling:
  - wvalid_o = ~fifo_empty_i.
  - wdata_o = fifo_data_i.
  - wlast_o = wvalid_o & (beat_cnt==0).
  - fifo_read_o = wvalid_o & wready_i.
- Strobes:
  - Single-beat burst (len 0): wstrb = first_strb & last_strb.
  - Otherwise the first beat uses first_strb, the last beat uses last_strb, and middle beats use all-ones.
  - wstrb_o is 0 whenever wvalid_o=0.
- Each handshake decrements beat_cnt and clears the first flag. A handshake with wlast_o=1 returns the FSM to IDLE and registers done_o=1 for the next cycle.
- Latency:
  - Command accepted in cycle N gives the earliest WVALID in cycle N+1.
  - The next command can be accepted in the cycle after the last beat, which is the same cycle done_o is high.
  - No bubble exists between beats when the FIFO is non-empty and WREADY=1.
- AXI stability: this block is the only popper of the FIFO, so once wvalid_o rises, data stays stable until WREADY.
- Stall handling: beat_cnt and wstrb are held while WREADY=0. An empty FIFO mid-burst drops wvalid_o until data arrives; this is legal between handshakes.
- Reset mid-burst: immediate return to IDLE with no done_o. Only a global reset may truncate a burst.
- cmd_len_i is 8 bits, so the maximum burst is 256 beats. Any FIFO_DEPTH is legal in streaming mode.

Optional Feature:
- Macro: DMA_WR_FULL_BURST_EN.
- Enabled:
  - After accept, the FSM enters WAIT_DATA and asserts wvalid_o only once fifo_ocup_i >= len+1. It then goes to STREAM, so W beats are never stalled by the FIFO.
  - A command with len+1 > FIFO_DEPTH is consumed with err_o=1 for one cycle. The FSM stays in IDLE, no beats are sent and no done_o is raised.
- Disabled: there is no WAIT_DATA state, beats stream as the FIFO fills, and err_o is tied to 0.

Decomposition:
- dma_pkg holds:
  - the axi_len_t (8-bit) typedef;
  - the wr_state_t enum {IDLE, WAIT_DATA, STREAM};
  - a dma_wr_cmd_t struct {len, first_strb, last_strb}.
- No sub-module. The beat counter and strobe mux stay inline.

Test Plan:
- len=0, first=4'b1110, last=4'b0011, FIFO holds 1 word 0xA5A5A5A5, WREADY=1 -> one beat with wstrb=4'b0010, wlast=1, fifo_read=1; done_o one cycle later.
- len=3, strobes 4'b1100 / 4'b0111, FIFO preloaded with 4 words, WREADY=1 -> 4 consecutive beats with wstrb 1100,1111,1111,0111; wlast only on beat 4; 4 pops.
- len=3 with WREADY toggling 1,0,0,1,... -> wdata/wstrb held across stalls; exactly 4 pops; done_o after the 4th handshake.
- Streaming mode, len=7, FIFO filled 1 word every 3 cycles -> wvalid_o gaps while the FIFO is empty; 8 beats in order; wlast on the 8th.
- Macro on, FIFO_DEPTH=16, len=20 -> err_o pulse, cmd_ready_o stays 1, zero beats. Then len=3 with ocup going 2→4 -> wvalid only after ocup=4.
- rst asserted after beat 2 of len=7 -> next cycle wvalid_o=0, cmd_ready_o=1, no done_o; a new command streams normally.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types for the DMA write-data streamer: AXI length, FSM states, command payload.
// DMA_DATA_WIDTH sets the strobe width carried by the command struct.
package dma_pkg;

    localparam int unsigned DMA_DATA_WIDTH = 32;
    localparam int unsigned DMA_STRB_WIDTH = DMA_DATA_WIDTH / 8;

    typedef logic [7:0] axi_len_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        STREAM    = 2'd2
    } wr_state_t;

    typedef struct packed {
        axi_len_t                  len;
        logic [DMA_STRB_WIDTH-1:0] first_strb;
        logic [DMA_STRB_WIDTH-1:0] last_strb;
    } dma_wr_cmd_t;

endpackage

// File: rtl/dma_wr_streamer_if.sv
// Command, FIFO read-side and AXI W-channel bundle for dma_wr_streamer.
// Signal suffixes are relative to the streamer (slave modport).
interface dma_wr_streamer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16
) ();
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OCUP_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    dma_pkg::axi_len_t     cmd_len_i;
    logic [STRB_WIDTH-1:0] cmd_first_strb_i;
    logic [STRB_WIDTH-1:0] cmd_last_strb_i;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  fifo_empty_i;
    logic [OCUP_WIDTH-1:0] fifo_ocup_i;
    logic                  fifo_read_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic [STRB_WIDTH-1:0] wstrb_o;
    logic                  wlast_o;
    logic                  wvalid_o;
    logic                  wready_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    modport master (
        output cmd_valid_i, cmd_len_i, cmd_first_strb_i, cmd_last_strb_i,
        output fifo_data_i, fifo_empty_i, fifo_ocup_i, wready_i,
        input  cmd_ready_o, fifo_read_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
        input  busy_o, done_o, err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_len_i, cmd_first_strb_i, cmd_last_strb_i,
        input  fifo_data_i, fifo_empty_i, fifo_ocup_i, wready_i,
        output cmd_ready_o, fifo_read_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
        output busy_o, done_o, err_o
    );
endinterface

// File: rtl/dma_wr_streamer.sv
// Pops the DMA data FIFO onto the AXI4 W channel, one burst per accepted command.
// Define DMA_WR_FULL_BURST_EN to hold each burst until the FIFO holds all of its beats.
module dma_wr_streamer
    import dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    dma_wr_streamer_if.slave bus
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    wr_state_t             state_q, state_d;
    axi_len_t              beat_cnt_q, beat_cnt_d;
    logic                  first_q, first_d;
    dma_wr_cmd_t           cmd_q, cmd_d;
    logic                  done_q, done_d;

    dma_wr_cmd_t           cmd_c;
    logic                  cmd_ready_c;
    logic                  accept_c;
    logic                  wvalid_c;
    logic                  hs_c;
    logic                  last_beat_c;
    logic                  cmd_fits_c;
    logic [STRB_WIDTH-1:0] first_strb_c;
    logic [STRB_WIDTH-1:0] last_strb_c;

`ifdef DMA_WR_FULL_BURST_EN
    logic                  err_q, err_d;
    logic                  data_ready_c;

    assign data_ready_c = 32'(bus.fifo_ocup_i) >= (32'(cmd_q.len) + 32'd1);
`else
    logic                  unused_c;

    assign unused_c = ^{bus.fifo_ocup_i, cmd_q.len, cmd_fits_c};
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            first_q    <= 1'b0;
            cmd_q      <= '0;
            done_q     <= 1'b0;
`ifdef DMA_WR_FULL_BURST_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            first_q    <= first_d;
            cmd_q      <= cmd_d;
            done_q     <= done_d;
`ifdef DMA_WR_FULL_BURST_EN
            err_q      <= err_d;
`endif
        end
    end

    // Next-state: command latch, beat countdown, completion
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        first_d    = first_q;
        cmd_d      = cmd_q;
        done_d     = 1'b0;
`ifdef DMA_WR_FULL_BURST_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cmd_d      = cmd_c;
                    beat_cnt_d = cmd_c.len;
                    first_d    = 1'b1;
`ifdef DMA_WR_FULL_BURST_EN
                    // A burst larger than the FIFO could never be buffered whole
                    if (cmd_fits_c) state_d = WAIT_DATA;
                    else            err_d   = 1'b1;
`else
                    state_d    = STREAM;
`endif
                end
            end
`ifdef DMA_WR_FULL_BURST_EN
            WAIT_DATA: begin
                if (data_ready_c) state_d = STREAM;
            end
`endif
            STREAM: begin
                if (hs_c) begin
                    beat_cnt_d = beat_cnt_q - 8'd1;
                    first_d    = 1'b0;
                    if (last_beat_c) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: W channel follows the FIFO head directly while streaming
    always_comb begin
        cmd_c.len        = bus.cmd_len_i;
        cmd_c.first_strb = DMA_STRB_WIDTH'(bus.cmd_first_strb_i);
        cmd_c.last_strb  = DMA_STRB_WIDTH'(bus.cmd_last_strb_i);
        cmd_fits_c       = (32'(cmd_c.len) + 32'd1) <= FIFO_DEPTH;
        first_strb_c     = STRB_WIDTH'(cmd_q.first_strb);
        last_strb_c      = STRB_WIDTH'(cmd_q.last_strb);

        cmd_ready_c = (state_q == IDLE);
        accept_c    = bus.cmd_valid_i & cmd_ready_c;
        wvalid_c    = (state_q == STREAM) & ~bus.fifo_empty_i;
        last_beat_c = (beat_cnt_q == '0);
        hs_c        = wvalid_c & bus.wready_i;

        bus.cmd_ready_o = cmd_ready_c;
        bus.wvalid_o    = wvalid_c;
        bus.wdata_o     = bus.fifo_data_i;
        bus.wlast_o     = wvalid_c & last_beat_c;
        bus.fifo_read_o = hs_c;
        bus.busy_o      = (state_q != IDLE);
        bus.done_o      = done_q;
        bus.wstrb_o     = '0;
        // Single-beat bursts get first & last applied together
        if (wvalid_c) begin
            bus.wstrb_o = (first_q ? first_strb_c : '1) & (last_beat_c ? last_strb_c : '1);
        end
`ifdef DMA_WR_FULL_BURST_EN
        bus.err_o = err_q;
`else
        bus.err_o = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dma_wr_streamer.sv
// Randomized scoreboard bench for dma_wr_streamer with a queue-based FIFO and AXI sink model.
// Optional checks follow DMA_WR_FULL_BURST_EN.
module tb_dma_wr_streamer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned OW    = $clog2(DEPTH) + 1;
`ifdef DMA_WR_FULL_BURST_EN
    localparam int LAT_EXTRA = 1;
    localparam int MAX_LEN   = 15;
`else
    localparam int LAT_EXTRA = 0;
    localparam int MAX_LEN   = 40;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_wr_streamer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    dma_wr_streamer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] fifo[$];
    logic [DW-1:0] feed_q[$];
    logic [DW-1:0] next_words[$];

    int feed_period = 1;
    int feed_cnt    = 0;
    int wr_mode     = 3;
    int cyc         = 0;
    int checks      = 0;
    int errors      = 0;
    int hs_count    = 0;
    int pop_count   = 0;
    int gap_count   = 0;
    logic done_pending = 1'b0;

    logic pop_now, rdy_now, wv_now, busy_now, err_now, wlast_now, done_now;
    int   ocup_now;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference strobe rule for beat i of a burst of len+1 beats
    function automatic logic [SW-1:0] exp_strb(input int i, input int len,
                                               input logic [SW-1:0] fs, input logic [SW-1:0] ls);
        if (len == 0) return fs & ls;
        if (i == 0)   return fs;
        if (i == len) return ls;
        return '1;
    endfunction

    task automatic drive_fifo();
        bus.fifo_empty_i = (fifo.size() == 0);
        bus.fifo_data_i  = (fifo.size() > 0) ? fifo[0] : '0;
        bus.fifo_ocup_i  = OW'(fifo.size());
    endtask

    // One clock: sample mid-cycle, then update FIFO model and WREADY after the edge
    task automatic tick();
        @(negedge clk);
        pop_now   = bus.fifo_read_o;
        rdy_now   = bus.cmd_ready_o;
        wv_now    = bus.wvalid_o;
        busy_now  = bus.busy_o;
        err_now   = bus.err_o;
        wlast_now = bus.wlast_o;
        done_now  = bus.done_o;
        ocup_now  = fifo.size();
        @(posedge clk);
        #1;
        cyc++;
        if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
        if (feed_q.size() > 0 && fifo.size() < DEPTH) begin
            feed_cnt++;
            if (feed_cnt >= feed_period) begin
                fifo.push_back(feed_q.pop_front());
                feed_cnt = 0;
            end
        end
        case (wr_mode)
            0:       bus.wready_i = 1'b1;
            1:       bus.wready_i = ($urandom_range(0, 3) != 0);
            2:       bus.wready_i = ((cyc % 3) == 0);
            default: bus.wready_i = 1'b0;
        endcase
        drive_fifo();
    endtask

    // period 0 preloads the FIFO, otherwise one word enters every period cycles
    task automatic issue(input int len, input logic [SW-1:0] fs, input logic [SW-1:0] ls,
                         input bit with_data, input int period);
        logic [DW-1:0] w;
        bit accepted;
        hs_count    = 0;
        pop_count   = 0;
        gap_count   = 0;
        feed_cnt    = 0;
        feed_period = (period == 0) ? 1 : period;
        if (with_data) begin
            for (int i = 0; i <= len; i++) begin
                w = (next_words.size() > 0) ? next_words.pop_front() : $urandom;
                exp_q.push_back('{w, exp_strb(i, len, fs, ls), (i == len)});
                if (period == 0 && fifo.size() < DEPTH) fifo.push_back(w);
                else                                   feed_q.push_back(w);
            end
        end
        bus.cmd_len_i        = 8'(len);
        bus.cmd_first_strb_i = fs;
        bus.cmd_last_strb_i  = ls;
        bus.cmd_valid_i      = 1'b1;
        drive_fifo();
        accepted = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (rdy_now) begin
                accepted = 1'b1;
                break;
            end
        end
        bus.cmd_valid_i = 1'b0;
        if (!accepted) check("cmd_accept_timeout", 0, 1);
    endtask

    // Runs until every expected beat is seen, then samples the done cycle
    task automatic wait_burst(input int len, output int n);
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) check("burst_timeout", 0, 1);
        tick();
        check("ready_in_done_cycle", rdy_now, 1);
        check("busy_after_burst", busy_now, 0);
        check("pop_count", pop_count, len + 1);
        check("beat_count", hs_count, len + 1);
    endtask

    // Scoreboard monitor: compares each W handshake with the oldest expected beat
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_strb;
    logic          hs;
    beat_t         e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall   = 1'b0;
            done_pending = 1'b0;
        end else begin
            hs = bus.wvalid_o & bus.wready_i;
            check("done_o", bus.done_o, done_pending);
            done_pending = 1'b0;
`ifndef DMA_WR_FULL_BURST_EN
            check("err_o", bus.err_o, 0);
`endif
            check("fifo_read_o", bus.fifo_read_o, hs);
            if (!bus.wvalid_o) begin
                check("wstrb_idle", bus.wstrb_o, 0);
                check("wlast_idle", bus.wlast_o, 0);
            end
            if (prev_stall) begin
                check("stall_wvalid", bus.wvalid_o, 1);
                check("stall_wdata", bus.wdata_o, prev_data);
                check("stall_wstrb", bus.wstrb_o, prev_strb);
            end
            if (bus.busy_o && !bus.wvalid_o) gap_count++;
            if (bus.fifo_read_o) pop_count++;
            if (hs) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wdata", bus.wdata_o, e.data);
                    check("wstrb", bus.wstrb_o, e.strb);
                    check("wlast", bus.wlast_o, e.last);
                    if (e.last) done_pending = 1'b1;
                end
            end
            prev_stall = bus.wvalid_o & ~bus.wready_i;
            prev_data  = bus.wdata_o;
            prev_strb  = bus.wstrb_o;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int mode;
        int period;
        logic [SW-1:0] fs, ls;

        rst                  = 1'b1;
        bus.cmd_valid_i      = 1'b0;
        bus.cmd_len_i        = '0;
        bus.cmd_first_strb_i = '0;
        bus.cmd_last_strb_i  = '0;
        bus.wready_i         = 1'b0;
        drive_fifo();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_cmd_ready", rdy_now, 1);
        check("rst_wvalid", wv_now, 0);
        check("rst_wlast", wlast_now, 0);
        check("rst_fifo_read", pop_now, 0);
        check("rst_busy", busy_now, 0);
        check("rst_done", done_now, 0);
        check("rst_err", err_now, 0);

        // Single beat, first & last strobes combined
        wr_mode = 0;
        next_words.push_back(32'hA5A5A5A5);
        issue(0, 4'b1110, 4'b0011, 1'b1, 0);
        wait_burst(0, n);
        check("len0_cycles", n, 1 + LAT_EXTRA);

        // Four preloaded beats, no bubbles
        issue(3, 4'b1100, 4'b0111, 1'b1, 0);
        wait_burst(3, n);
        check("len3_cycles", n, 4 + LAT_EXTRA);

        // WREADY 1,0,0 pattern: data must hold across stalls
        wr_mode = 2;
        issue(3, 4'b1010, 4'b0101, 1'b1, 0);
        wait_burst(3, n);

        // Slow FIFO fill: WVALID gaps in streaming mode
        wr_mode = 0;
        issue(7, 4'b1000, 4'b0001, 1'b1, 3);
        wait_burst(7, n);
        check("slow_fill_gaps", (gap_count > 0), 1);

`ifdef DMA_WR_FULL_BURST_EN
        // Oversized command is rejected without beats
        issue(20, 4'b1111, 4'b1111, 1'b0, 0);
        tick();
        check("oversize_err", err_now, 1);
        check("oversize_ready", rdy_now, 1);
        check("oversize_wvalid", wv_now, 0);
        tick();
        check("oversize_err_pulse", err_now, 0);
        check("oversize_no_beats", hs_count, 0);

        // WVALID only once the whole burst is buffered
        issue(3, 4'b0110, 4'b1001, 1'b1, 3);
        n = 0;
        while (!wv_now && n < 200) begin
            tick();
            n++;
        end
        check("full_burst_ocup", (ocup_now >= 4), 1);
        wait_burst(3, n);
`endif

        // Random commands, strobes, fill rates and WREADY
        for (int t = 0; t < 25; t++) begin
            len     = $urandom_range(0, MAX_LEN);
            fs      = SW'($urandom);
            ls      = SW'($urandom);
            mode    = $urandom_range(0, 2);
            period  = $urandom_range(0, 3);
            wr_mode = mode;
            issue(len, fs, ls, 1'b1, period);
            wait_burst(len, n);
        end

        // Reset after beat 2 of an 8-beat burst
        wr_mode = 0;
        issue(7, 4'b1111, 4'b1111, 1'b1, 0);
        n = 0;
        while (hs_count < 2 && n < 200) begin
            tick();
            n++;
        end
        check("reset_test_two_beats", hs_count, 2);
        rst          = 1'b1;
        wr_mode      = 3;
        bus.wready_i = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        wr_mode = 0;
        tick();
        check("midrst_wvalid", wv_now, 0);
        check("midrst_ready", rdy_now, 1);
        check("midrst_busy", busy_now, 0);
        check("midrst_done", done_now, 0);
        fifo.delete();
        feed_q.delete();
        drive_fifo();
        issue(2, 4'b0011, 4'b1100, 1'b1, 0);
        wait_burst(2, n);
        check("post_rst_cycles", n, 3 + LAT_EXTRA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
